// File: rtl/keypad_cmd_scheduler.sv
// keypad_cmd_scheduler
//   Scans a 4x3 matrix keypad, debounces full-scan results and turns stable
//   presses into one-shot game commands on a valid/ready handshake.
//
//   Optional build macro: KEY_REPEAT_EN - auto-repeat of the held key's
//   command every REPEAT_FRAMES frames.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   key_col_i    column sense (100 left, 010 middle, 001 right)
//   key_row_o    one-hot row drive, 1000 -> 0100 -> 0010 -> 0001
//   cmd_valid_o  command pending
//   cmd_ready_i  consumer takes the pending command
//   cmd_o        0 up, 1 left, 2 put, 3 right, 4 undo, 5 down
//   key_value_o  debounced key code, 4'hf when nothing is held
//   drop_flag_o  sticky: a command was lost to a stalled consumer
module keypad_cmd_scheduler #(
  parameter int SCAN_DIV      = 16,
  parameter int DEB_FRAMES    = 3,
  parameter int REPEAT_FRAMES = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] key_col_i,
  output logic [3:0] key_row_o,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic [2:0] cmd_o,
  output logic [3:0] key_value_o,
  output logic       drop_flag_o
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_FRAMES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_C    = CW'(DEB_FRAMES);
  localparam logic [3:0]    NONE     = 4'hf;

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HELD, S_REL} state_e;

  // ---------------- scan ----------------
  logic [2:0]    sync1_q, sync2_q;
  logic [DW-1:0] div_q;
  logic [1:0]    row_q;
  logic [3:0]    acc_q, frame_q, samp, acc_next;
  logic          eval_q, row_last;

  function automatic logic [3:0] decode(input logic [1:0] row, input logic [2:0] col);
    logic [1:0] c;
    logic       ok;
    logic [3:0] k;
    c  = 2'd0;
    ok = 1'b1;
    k  = NONE;
    case (col)
      3'b100:  c = 2'd0;
      3'b010:  c = 2'd1;
      3'b001:  c = 2'd2;
      default: ok = 1'b0;   // no key, or several keys in one row
    endcase
    if (ok) begin
      case (row)
        2'd0:    k = 4'd1 + {2'b00, c};
        2'd1:    k = 4'd4 + {2'b00, c};
        2'd2:    k = 4'd7 + {2'b00, c};
        default: k = (c == 2'd0) ? 4'hc : (c == 2'd1) ? 4'h0 : 4'hd;
      endcase
    end
    return k;
  endfunction

  assign row_last = (div_q == DIV_LAST);
  assign samp     = decode(row_q, sync2_q);
  // First row in scan order holding a valid key wins the frame.
  assign acc_next = (acc_q != NONE) ? acc_q : samp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      row_q   <= '0;
      acc_q   <= NONE;
      frame_q <= NONE;
      eval_q  <= 1'b0;
    end else begin
      sync1_q <= key_col_i;
      sync2_q <= sync1_q;
      eval_q  <= 1'b0;
      if (row_last) begin
        div_q <= '0;
        row_q <= row_q + 2'd1;
        if (row_q == 2'd3) begin
          frame_q <= acc_next;
          acc_q   <= NONE;
          eval_q  <= 1'b1;
        end else begin
          acc_q <= acc_next;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign key_row_o = 4'b1000 >> row_q;

  // ---------------- debounce ----------------
  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;   // press count in PRESS, release count in REL
  logic          issue, issue_all, map_ok, rep_fire;
  logic [2:0]    mcmd;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    if (eval_q) begin
      case (state_q)
        S_IDLE: if (frame_q != NONE) begin
          cand_d = frame_q;
          cnt_d  = {{(CW-1){1'b0}}, 1'b1};
          if (DEB_FRAMES == 1) begin
            state_d = S_HELD;
            issue   = 1'b1;
          end else begin
            state_d = S_PRESS;
          end
        end
        S_PRESS: begin
          if (frame_q == NONE) begin
            state_d = S_IDLE;
          end else if (frame_q == cand_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DEB_C) begin
              state_d = S_HELD;
              issue   = 1'b1;
            end
          end else begin
            cand_d = frame_q;
            cnt_d  = {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_HELD: if (frame_q == NONE) begin
          cnt_d   = {{(CW-1){1'b0}}, 1'b1};
          state_d = (DEB_FRAMES == 1) ? S_IDLE : S_REL;
        end
        default: begin  // S_REL; another key while releasing is ignored
          if (frame_q == NONE) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DEB_C) state_d = S_IDLE;
          end else if (frame_q == cand_q) begin
            state_d = S_HELD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cand_q  <= NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_value_o = (state_q == S_HELD || state_q == S_REL) ? cand_q : NONE;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_C = RW'(REPEAT_FRAMES);
  logic [RW-1:0] rep_q, rep_d;

  // Counts frames spent in HELD; restarts on entry and after each repeat.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (state_d == S_HELD) begin
      if (state_q != S_HELD) begin
        rep_d = '0;
      end else if (eval_q) begin
        rep_d = rep_q + 1'b1;
        if (rep_d == REP_C) begin
          rep_fire = 1'b1;
          rep_d    = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rep_q <= '0;
    else         rep_q <= rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  // ---------------- command output ----------------
  assign issue_all = issue | rep_fire;

  always_comb begin
    map_ok = 1'b1;
    mcmd   = 3'd0;
    case (cand_d)
      4'h5:    mcmd = 3'd0;
      4'h7:    mcmd = 3'd1;
      4'h8:    mcmd = 3'd2;
      4'h9:    mcmd = 3'd3;
      4'hc:    mcmd = 3'd4;
      4'h0:    mcmd = 3'd5;
      default: map_ok = 1'b0;
    endcase
  end

  logic       cmd_valid_q, drop_q;
  logic [2:0] cmd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= 3'd0;
      drop_q      <= 1'b0;
    end else if (issue_all && map_ok) begin
      // A stalled pending command is never overwritten.
      if (cmd_valid_q && !cmd_ready_i) begin
        drop_q <= 1'b1;
      end else begin
        cmd_q       <= mcmd;
        cmd_valid_q <= 1'b1;
      end
    end else if (cmd_valid_q && cmd_ready_i) begin
      cmd_valid_q <= 1'b0;
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_o       = cmd_q;
  assign drop_flag_o = drop_q;

endmodule

// File: doc/keypad_cmd_scheduler.md
Name: keypad_cmd_scheduler

Overview:
Drives the 4x3 matrix keypad scan and converts stable key presses into one-shot cursor/game commands for the OMOK game FSM. Owns the key_row drive, synchronizes and debounces key_col, and decodes keys to move codes. Commands are delivered over a valid/ready handshake so the game FSM can stall without losing the pending command.

Parameters:
SCAN_DIV, 16, clock cycles each row is driven before key_col is sampled; legal range is at least 4.
DEB_FRAMES, 3, consecutive identical full-scan results required to accept a press or a release; legal range is at least 1.
REPEAT_FRAMES, 32, frames a key must be held before auto-repeat fires; used only with KEY_REPEAT_EN.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
key_col  in  3  keypad column sense, one-hot when a key is pressed (100 = left, 010 = middle, 001 = right)
key_row  out  4  one-hot row drive: 1000, 0100, 0010, 0001
cmd_valid  out  1  command available
cmd_ready  in  1  consumer accepts the command
cmd  out  3  0 up, 1 left, 2 put, 3 right, 4 undo, 5 down
key_value  out  4  last debounced raw key code; 4'hf when no key is held
drop_flag  out  1  sticky flag: a command was discarded because the previous one was still pending

Behaviour:
- Reset values: key_row=1000, cmd_valid=0, cmd=0, key_value=4'hf, drop_flag=0. All counters and the synchronizer are cleared. Reset mid-frame aborts the frame; no partial result is used.
- key_col passes through a 2-flop synchronizer.
- Row dwell counter runs 0..SCAN_DIV-1. On the last dwell cycle:
  - The synchronized col is sampled for the current row.
  - key_row rotates 1000 -> 0100 -> 0010 -> 0001 -> 1000.
- One frame is 4*SCAN_DIV cycles.
- Key map:
  - Row 1000: 1, 2, 3.
  - Row 0100: 4, 5, 6.
  - Row 0010: 7, 8, 9.
  - Row 0001: c, 0, d.
  - Columns are listed in order 100, 010, 001.
  - A column sample that is zero or not one-hot means no key for that row.
- Frame result: the first row in scan order with a valid key wins. If no row has a valid key, the result is NONE (4'hf).
- Debounce FSM, evaluated once per frame in a single EVAL cycle after row 0001's sample:
  - IDLE: a non-NONE result loads cand and sets cnt=1, go to PRESS. If DEB_FRAMES=1, go directly to HELD and issue.
  - PRESS: a result equal to cand increments cnt; cnt reaching DEB_FRAMES goes to HELD and issues a command. A different result reloads cand with cnt=1; a NONE result goes to IDLE.
  - HELD: key_value=cand. A NONE result sets rcnt=1 and goes to REL. A different non-NONE result is ignored; there is no roll-over.
  - REL: NONE increments rcnt; rcnt reaching DEB_FRAMES goes to IDLE with key_value=4'hf. A result equal to cand returns to HELD with no new command.
- Issue:
  - Only keys 5, 7, 8, 9, c and 0 map to commands: 5 -> 0, 7 -> 1, 8 -> 2, 9 -> 3, c -> 4, 0 -> 5.
  - Other keys update key_value but issue nothing.
  - cmd_valid rises the cycle after EVAL. cmd and cmd_valid hold until the first cycle with cmd_valid and cmd_ready both high, then cmd_valid=0 on the next cycle.
- Pending collision: if an issue occurs while cmd_valid=1 and cmd_ready=0, the new command is dropped, drop_flag is set, and the old cmd is unchanged.
- drop_flag clears only on reset.
- cmd_ready while cmd_valid=0 is ignored.

Optional Feature:
KEY_REPEAT_EN
- When defined: in HELD, a frame counter reissues the same command every REPEAT_FRAMES frames while the key stays held. Repeats are subject to the same drop rule. The counter resets on entry to HELD and on each repeat.
- When undefined: exactly one command per press; REPEAT_FRAMES is unused.

Test Plan:
All scenarios use SCAN_DIV=4 and DEB_FRAMES=2, so one frame is 16 cycles.
- Reset: hold rst=0 -> key_row=1000, cmd_valid=0, key_value=f, drop_flag=0. Release -> key_row steps to 0100 after 4 cycles and back to 1000 at cycle 16.
- Right press, cmd_ready=1: drive key_col=001 whenever key_row=0010 for 3 frames -> exactly one cmd=3 pulse, one cycle wide, after the 2nd frame; key_value=9 while held. Then key_col=000 for 2 frames -> key_value=f.
- Stall: press 5 (up) with cmd_ready=0 -> cmd_valid=1, cmd=0 held stable for 50 cycles. Raise cmd_ready -> cmd_valid=0 next cycle.
- Drop: keep cmd_ready=0, press 8, release 2 frames, press 7 -> cmd stays 2, drop_flag=1 and stays 1.
- Bounce: key 0 on row 0001 for 1 frame, off 1 frame, on 1 frame -> no cmd. Then held 2 frames -> cmd=5.
- Multi-key and invalid col: key_col=011 on row 0010 and key 5 on row 0100 for 2 frames -> cmd=0, from row 0100, which is scanned first. With KEY_REPEAT_EN, REPEAT_FRAMES=4, and right (9) held for 12 frames with cmd_ready=1 -> cmd=3 issued 3 times.
